// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer slice: buffer geometry, default
// colours and the write-controller state encoding.
package vga_pkg;

  localparam int unsigned FB_ADDR_W = 15;
  localparam int unsigned FB_DEPTH  = 2 ** FB_ADDR_W;
  localparam int unsigned FB_X_W    = 8;
  localparam int unsigned FB_Y_W    = 7;

  // [15:8] foreground, [7:0] background
  localparam logic [15:0] FB_DEFAULT_COLOURS = 16'hFF00;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFillWait = 2'd1,
    StFill     = 2'd2
  } fb_state_e;

  function automatic logic [FB_ADDR_W-1:0] fb_pixel_addr(input logic [FB_X_W-1:0] x,
                                                         input logic [FB_Y_W-1:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/vga_fb_ctrl_if.sv
// Host pixel-write handshake into the frame-buffer write controller.
interface vga_fb_ctrl_if #(
  parameter int unsigned ADDR_W = 15
);

  logic              WR_VALID;
  logic              WR_READY;
  logic [ADDR_W-1:0] WR_ADDR;
  logic              WR_DATA;

  modport master (output WR_VALID, output WR_ADDR, output WR_DATA, input WR_READY);
  modport slave  (input WR_VALID, input WR_ADDR, input WR_DATA, output WR_READY);

endinterface

// File: rtl/vga_vs_sync_edge.sv
// Brings the pixel-clock VGA_VS into the system domain and emits a registered
// one-cycle FRAME_TICK on its falling edge (3 cycles after VS falls).
module vga_vs_sync_edge (
  input  logic CLK,
  input  logic RESET,
  input  logic VGA_VS,
  output logic FRAME_TICK
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic dly_q, dly_d;
  logic tick_q, tick_d;

  always_comb begin
    sync1_d = VGA_VS;
    sync2_d = sync1_q;
    dly_d   = sync2_q;
    tick_d  = !sync2_q && dly_q;
  end

  // Synchroniser flops reset high so leaving reset never looks like a VS fall.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      dly_q   <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      dly_q   <= dly_d;
      tick_q  <= tick_d;
    end
  end

  assign FRAME_TICK = tick_q;

endmodule

// File: rtl/vga_fb_ctrl.sv
// Port-A write controller for the 256x128 1-bit frame buffer: host pixel
// writes, whole-screen fills and frame-aligned colour updates.
module vga_fb_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned ADDR_W          = FB_ADDR_W,
  parameter bit          FILL_SYNC       = 1'b1,
  parameter logic [15:0] DEFAULT_COLOURS = FB_DEFAULT_COLOURS
) (
  input  logic              CLK,
  input  logic              RESET,
  vga_fb_ctrl_if.slave      wr_if,
  input  logic              FILL_START,
  input  logic              FILL_VALUE,
  output logic              FILL_DONE,
  output logic              BUSY,
  input  logic              COLOUR_WE,
  input  logic [15:0]       COLOUR_IN,
  output logic [15:0]       CONFIG_COLOURS,
  input  logic              VGA_VS,
  output logic              FRAME_TICK,
  output logic              FB_WE_A,
  output logic [ADDR_W-1:0] FB_ADDR_A,
  output logic              FB_DATA_A
);

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              fill_val_q, fill_val_d;
  logic              fb_we_q, fb_we_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic              fb_data_q, fb_data_d;
  logic              done_q, done_d;
  logic [15:0]       colours_q, colours_d;
  logic [15:0]       pend_q, pend_d;
  logic              pend_flag_q, pend_flag_d;
  logic              frame_tick;
  logic              wr_ready;

  vga_vs_sync_edge u_vs_sync_edge (
    .CLK        (CLK),
    .RESET      (RESET),
    .VGA_VS     (VGA_VS),
    .FRAME_TICK (frame_tick)
  );

  assign wr_ready = (state_q == StIdle) && !FILL_START;

  // During a fill cnt_q always equals the address currently on port A.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_val_d = fill_val_q;
    fb_we_d    = 1'b0;
    fb_addr_d  = fb_addr_q;
    fb_data_d  = fb_data_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (FILL_START) begin
          fill_val_d = FILL_VALUE;
          cnt_d      = '0;
          if (FILL_SYNC) begin
            state_d = StFillWait;
          end else begin
            state_d   = StFill;
            fb_we_d   = 1'b1;
            fb_addr_d = '0;
            fb_data_d = FILL_VALUE;
          end
        end else if (wr_if.WR_VALID) begin
          fb_we_d   = 1'b1;
          fb_addr_d = wr_if.WR_ADDR;
          fb_data_d = wr_if.WR_DATA;
        end
      end
      StFillWait: begin
        if (frame_tick) begin
          state_d   = StFill;
          fb_we_d   = 1'b1;
          fb_addr_d = '0;
          fb_data_d = fill_val_q;
        end
      end
      StFill: begin
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d     = cnt_q + ADDR_W'(1);
          fb_we_d   = 1'b1;
          fb_addr_d = cnt_q + ADDR_W'(1);
          fb_data_d = fill_val_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A write on the tick itself restages and defers the apply to the next frame.
  always_comb begin
    colours_d   = colours_q;
    pend_d      = pend_q;
    pend_flag_d = pend_flag_q;
    if (COLOUR_WE) begin
      pend_d      = COLOUR_IN;
      pend_flag_d = 1'b1;
    end else if (frame_tick && pend_flag_q) begin
      colours_d   = pend_q;
      pend_flag_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      fill_val_q  <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= 1'b0;
      done_q      <= 1'b0;
      colours_q   <= DEFAULT_COLOURS;
      pend_q      <= '0;
      pend_flag_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_val_q  <= fill_val_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
      done_q      <= done_d;
      colours_q   <= colours_d;
      pend_q      <= pend_d;
      pend_flag_q <= pend_flag_d;
    end
  end

  assign wr_if.WR_READY = wr_ready;
  assign FILL_DONE      = done_q;
  assign BUSY           = (state_q != StIdle);
  assign CONFIG_COLOURS = colours_q;
  assign FRAME_TICK     = frame_tick;
  assign FB_WE_A        = fb_we_q;
  assign FB_ADDR_A      = fb_addr_q;
  assign FB_DATA_A      = fb_data_q;

endmodule

// File: tb/tb_vga_fb_ctrl.sv
// Directed + randomized bench for vga_fb_ctrl: writes, synced fill, colour
// staging and reset mid-fill.
module tb_vga_fb_ctrl;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FILL_START = 1'b0;
  logic        FILL_VALUE = 1'b0;
  logic        FILL_DONE;
  logic        BUSY;
  logic        COLOUR_WE = 1'b0;
  logic [15:0] COLOUR_IN = '0;
  logic [15:0] CONFIG_COLOURS;
  logic        VGA_VS = 1'b1;
  logic        FRAME_TICK;
  logic        FB_WE_A;
  logic [14:0] FB_ADDR_A;
  logic        FB_DATA_A;

  int checks = 0;
  int errors = 0;

  vga_fb_ctrl_if #(.ADDR_W(15)) wr_if ();

  vga_fb_ctrl #(
    .ADDR_W          (15),
    .FILL_SYNC       (1'b1),
    .DEFAULT_COLOURS (16'hFF00)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .wr_if          (wr_if),
    .FILL_START     (FILL_START),
    .FILL_VALUE     (FILL_VALUE),
    .FILL_DONE      (FILL_DONE),
    .BUSY           (BUSY),
    .COLOUR_WE      (COLOUR_WE),
    .COLOUR_IN      (COLOUR_IN),
    .CONFIG_COLOURS (CONFIG_COLOURS),
    .VGA_VS         (VGA_VS),
    .FRAME_TICK     (FRAME_TICK),
    .FB_WE_A        (FB_WE_A),
    .FB_ADDR_A      (FB_ADDR_A),
    .FB_DATA_A      (FB_DATA_A)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drops VS and returns in the cycle FRAME_TICK should be high.
  task automatic vs_tick(input string tag);
    VGA_VS = 1'b0;
    step();
    check({tag, "_early"}, 32'(FRAME_TICK), 32'(0));
    step();
    step();
    check(tag, 32'(FRAME_TICK), 32'(1));
    VGA_VS = 1'b1;
  endtask

  initial begin
    logic [14:0] a;
    logic        d;
    logic        exp_we;
    logic [14:0] exp_addr;
    logic        exp_data;
    logic [15:0] c2, c3, c4;
    logic        fv;
    int          seen;

    wr_if.WR_VALID = 1'b0;
    wr_if.WR_ADDR  = '0;
    wr_if.WR_DATA  = 1'b0;

    // Reset and idle
    repeat (3) step();
    RESET = 1'b0;
    repeat (10) step();
    check("rst_colours", 32'(CONFIG_COLOURS), 32'(16'hFF00));
    check("rst_we", 32'(FB_WE_A), 32'(0));
    check("rst_addr", 32'(FB_ADDR_A), 32'(0));
    check("rst_busy", 32'(BUSY), 32'(0));
    check("rst_ready", 32'(wr_if.WR_READY), 32'(1));
    check("rst_tick", 32'(FRAME_TICK), 32'(0));

    // Single write, then three back-to-back
    wr_if.WR_VALID = 1'b1;
    wr_if.WR_ADDR  = 15'h1234;
    wr_if.WR_DATA  = 1'b1;
    step();
    wr_if.WR_VALID = 1'b0;
    check("wr_single", 32'({FB_WE_A, FB_ADDR_A, FB_DATA_A}), 32'({1'b1, 15'h1234, 1'b1}));
    step();
    check("wr_single_off", 32'(FB_WE_A), 32'(0));
    for (int j = 0; j < 3; j++) begin
      a = 15'($urandom);
      d = 1'($urandom);
      wr_if.WR_VALID = 1'b1;
      wr_if.WR_ADDR  = a;
      wr_if.WR_DATA  = d;
      step();
      check("wr_b2b", 32'({FB_WE_A, FB_ADDR_A, FB_DATA_A}), 32'({1'b1, a, d}));
    end
    wr_if.WR_VALID = 1'b0;
    step();
    check("wr_b2b_end", 32'(FB_WE_A), 32'(0));

    // Random write traffic: each accepted request appears on port A next cycle
    for (int j = 0; j < 300; j++) begin
      exp_we   = ($urandom_range(0, 3) != 0);
      exp_addr = 15'($urandom);
      exp_data = 1'($urandom);
      wr_if.WR_VALID = exp_we;
      wr_if.WR_ADDR  = exp_addr;
      wr_if.WR_DATA  = exp_data;
      #1;
      check("rnd_ready", 32'(wr_if.WR_READY), 32'(1));
      step();
      if (exp_we) begin
        check("rnd_wr", 32'({FB_WE_A, FB_ADDR_A, FB_DATA_A}), 32'({1'b1, exp_addr, exp_data}));
      end else begin
        check("rnd_idle", 32'(FB_WE_A), 32'(0));
      end
    end
    wr_if.WR_VALID = 1'b0;
    repeat (5) step();

    // Colour staged mid-frame applies at the next tick only
    COLOUR_WE = 1'b1;
    COLOUR_IN = 16'h1C03;
    step();
    COLOUR_WE = 1'b0;
    repeat (5) step();
    check("col_hold", 32'(CONFIG_COLOURS), 32'(16'hFF00));
    vs_tick("col_tick1");
    check("col_at_tick", 32'(CONFIG_COLOURS), 32'(16'hFF00));
    step();
    check("col_applied", 32'(CONFIG_COLOURS), 32'(16'h1C03));
    check("tick_one_cycle", 32'(FRAME_TICK), 32'(0));
    repeat (5) step();

    // Colour write coincident with the tick is deferred a whole frame
    c2 = 16'($urandom_range(0, 16'h1C02));
    vs_tick("col_tick2");
    COLOUR_WE = 1'b1;
    COLOUR_IN = c2;
    step();
    COLOUR_WE = 1'b0;
    check("col_coincident", 32'(CONFIG_COLOURS), 32'(16'h1C03));
    repeat (6) step();
    check("col_coincident_hold", 32'(CONFIG_COLOURS), 32'(16'h1C03));
    vs_tick("col_tick3");
    step();
    check("col_deferred", 32'(CONFIG_COLOURS), 32'(c2));
    repeat (5) step();

    // Last of several staged colours wins
    c3 = 16'($urandom);
    c4 = c3 ^ 16'h5A5A;
    COLOUR_WE = 1'b1;
    COLOUR_IN = c3;
    step();
    COLOUR_IN = c4;
    step();
    COLOUR_WE = 1'b0;
    repeat (3) step();
    vs_tick("col_tick4");
    step();
    check("col_last_wins", 32'(CONFIG_COLOURS), 32'(c4));
    repeat (5) step();

    // Synced fill colliding with a host write; the write waits for FILL_DONE
    a = 15'($urandom);
    d = 1'($urandom);
    FILL_START     = 1'b1;
    FILL_VALUE     = 1'b1;
    wr_if.WR_VALID = 1'b1;
    wr_if.WR_ADDR  = a;
    wr_if.WR_DATA  = d;
    #1;
    check("fill_ready_blocked", 32'(wr_if.WR_READY), 32'(0));
    step();
    FILL_START = 1'b0;
    FILL_VALUE = 1'b0;
    check("fill_busy", 32'(BUSY), 32'(1));
    check("fill_ready_busy", 32'(wr_if.WR_READY), 32'(0));
    check("fill_no_host_wr", 32'(FB_WE_A), 32'(0));
    seen = 0;
    repeat (500) begin
      step();
      if (FB_WE_A) seen++;
    end
    check("fill_wait_writes", 32'(seen), 32'(0));
    check("fill_wait_busy", 32'(BUSY), 32'(1));
    vs_tick("fill_tick");
    check("fill_tick_we", 32'(FB_WE_A), 32'(0));
    seen = 0;
    for (int i = 0; i < 32768; i++) begin
      step();
      if ({BUSY, FB_WE_A, FB_ADDR_A, FB_DATA_A} !== {1'b1, 1'b1, 15'(i), 1'b1}) seen++;
      if (i < 4 || i == 32767) begin
        check("fill_wr", 32'({BUSY, FB_WE_A, FB_ADDR_A, FB_DATA_A}),
              32'({1'b1, 1'b1, 15'(i), 1'b1}));
      end
    end
    check("fill_bad_cycles", 32'(seen), 32'(0));
    step();
    check("fill_done", 32'(FILL_DONE), 32'(1));
    check("fill_done_busy", 32'(BUSY), 32'(0));
    check("fill_done_we", 32'(FB_WE_A), 32'(0));
    check("fill_done_ready", 32'(wr_if.WR_READY), 32'(1));
    step();
    wr_if.WR_VALID = 1'b0;
    check("stalled_wr", 32'({FB_WE_A, FB_ADDR_A, FB_DATA_A}), 32'({1'b1, a, d}));
    check("done_pulse", 32'(FILL_DONE), 32'(0));
    step();
    check("stalled_wr_once", 32'(FB_WE_A), 32'(0));
    repeat (5) step();

    // Reset at fill address 100 aborts the fill and drops the staged colour
    fv = 1'($urandom);
    FILL_START = 1'b1;
    FILL_VALUE = fv;
    step();
    FILL_START = 1'b0;
    repeat (5) step();
    vs_tick("abort_tick");
    step();
    check("abort_first", 32'({FB_WE_A, FB_ADDR_A, FB_DATA_A}), 32'({1'b1, 15'd0, fv}));
    COLOUR_WE = 1'b1;
    COLOUR_IN = 16'hABCD;
    step();
    COLOUR_WE = 1'b0;
    repeat (99) step();
    check("abort_at100", 32'({FB_WE_A, FB_ADDR_A, FB_DATA_A}), 32'({1'b1, 15'd100, fv}));
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    check("abort_we", 32'(FB_WE_A), 32'(0));
    check("abort_busy", 32'(BUSY), 32'(0));
    check("abort_colours", 32'(CONFIG_COLOURS), 32'(16'hFF00));
    seen = 0;
    repeat (6) begin
      step();
      if (FILL_DONE || FB_WE_A) seen++;
    end
    check("abort_no_done", 32'(seen), 32'(0));
    vs_tick("abort_tick2");
    step();
    check("abort_discard_col", 32'(CONFIG_COLOURS), 32'(16'hFF00));
    check("abort_idle_we", 32'(FB_WE_A), 32'(0));
    check("abort_idle_ready", 32'(wr_if.WR_READY), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
